// File: rtl/array_arbiter_pkg.sv
// Shared types for the two-client array arbiter: slot state, client index
// and the registered request slot layout.
package array_arbiter_pkg;

  localparam int ADDR_N   = 8;
  localparam int INT_N    = 8;
  localparam int CLIENT_W = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  typedef logic [CLIENT_W-1:0] client_t;

  typedef struct packed {
    logic [ADDR_N-1:0] addr;
    logic              we;
    logic [INT_N-1:0]  di;
  } slot_t;

endpackage

// File: rtl/array_arbiter_if.sv
// Bundle of both client request/response ports and the shared array port.
interface array_arbiter_if;
  import array_arbiter_pkg::*;

  logic              c0_valid, c1_valid;
  logic              c0_ready, c1_ready;
  logic [ADDR_N-1:0] c0_addr, c1_addr;
  logic              c0_we, c1_we;
  logic [INT_N-1:0]  c0_di, c1_di;
  logic [INT_N-1:0]  c0_do, c1_do;
  logic              c0_do_valid, c1_do_valid;

  logic              arr_valid;
  logic              arr_ready;
  logic [ADDR_N-1:0] arr_addr;
  logic              arr_we;
  logic [INT_N-1:0]  arr_di;
  logic [INT_N-1:0]  arr_do;

  // Arbiter side: serves the clients, drives the array port.
  modport master (
    input  c0_valid, c1_valid, c0_addr, c1_addr, c0_we, c1_we, c0_di, c1_di,
    output c0_ready, c1_ready, c0_do, c1_do, c0_do_valid, c1_do_valid,
    output arr_valid, arr_addr, arr_we, arr_di,
    input  arr_ready, arr_do
  );

  // Environment side: the clients and the array itself.
  modport slave (
    output c0_valid, c1_valid, c0_addr, c1_addr, c0_we, c1_we, c0_di, c1_di,
    input  c0_ready, c1_ready, c0_do, c1_do, c0_do_valid, c1_do_valid,
    input  arr_valid, arr_addr, arr_we, arr_di,
    output arr_ready, arr_do
  );

endinterface

// File: rtl/array_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes
// to the client that was not granted last.
module array_arbiter_rr_pick2
  import array_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  client_t    i_last,
  output client_t    o_winner,
  output logic       o_any
);

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    o_any    = |i_valid;
    o_winner = client_t'(i_valid[1]);
    if (i_valid == 2'b11) o_winner = ~i_last;
  end

endmodule

// File: rtl/array_arbiter.sv
// Round-robin arbiter sharing one array port between two clients through a
// single registered request slot; read data is routed back to its issuer.
module array_arbiter
  import array_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          nrst,
  array_arbiter_if.master bus
);

  slot_state_e r_state, w_state_next;
  slot_t       r_slot, w_req;
  client_t     r_owner, r_last, r_rd_owner;
  logic        r_rd_pend;

  client_t     w_winner;
  logic        w_any, w_can_load, w_load, w_rd_accept;

  array_arbiter_rr_pick2 u_pick (
    .i_valid  ({bus.c1_valid, bus.c0_valid}),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Slot refills in the same cycle it drains, so a steady stream sees no gaps.
  always_comb begin
    w_state_next = r_state;
    w_can_load   = (r_state == EMPTY) || bus.arr_ready;
    w_load       = w_can_load && w_any && nrst;
    w_rd_accept  = (r_state == FULL) && bus.arr_ready && !r_slot.we;
    w_req        = w_winner[0] ? {bus.c1_addr, bus.c1_we, bus.c1_di}
                               : {bus.c0_addr, bus.c0_we, bus.c0_di};
    if (w_load)                                  w_state_next = FULL;
    else if (r_state == FULL && bus.arr_ready)   w_state_next = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= EMPTY;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_slot     <= '0;
      r_owner    <= '0;
      r_last     <= client_t'(1);
      r_rd_pend  <= 1'b0;
      r_rd_owner <= '0;
    end else begin
      if (w_load) begin
        r_slot  <= w_req;
        r_owner <= w_winner;
        r_last  <= w_winner;
      end
      r_rd_pend <= w_rd_accept;
      if (w_rd_accept) r_rd_owner <= r_owner;
    end
  end

  assign bus.c0_ready    = w_load && (w_winner == client_t'(0));
  assign bus.c1_ready    = w_load && (w_winner == client_t'(1));

  assign bus.arr_valid   = (r_state == FULL);
  assign bus.arr_addr    = r_slot.addr;
  assign bus.arr_we      = r_slot.we;
  assign bus.arr_di      = r_slot.di;

  // Array read data is valid one cycle after acceptance; only the strobe is steered.
  assign bus.c0_do       = bus.arr_do;
  assign bus.c1_do       = bus.arr_do;
  assign bus.c0_do_valid = r_rd_pend && (r_rd_owner == client_t'(0));
  assign bus.c1_do_valid = r_rd_pend && (r_rd_owner == client_t'(1));

endmodule

// File: doc/array_arbiter.md
# array_arbiter

Two-client round-robin arbiter that shares one `array` memory port between independent requesters, e.g. an `io_stream_read_array` instance and a writer/reader elsewhere in the generated design. It accepts one request per cycle from the selected client into a registered output slot, drives the array's valid/ready port from that slot, and routes each read result back to the client that issued it one cycle after the array accepts the read.

## Interface
- `addrN`, 8, address width (matches array `addr`)
- `intN`, 8, data width (matches array `di`/`do`)

- `clk`  in  1  clock, all state on rising edge
- `nrst`  in  1  asynchronous, active-low reset
- `c0_valid`, `c1_valid`  in  1  client request valid
- `c0_ready`, `c1_ready`  out  1  client request accepted this cycle when valid&ready
- `c0_addr`, `c1_addr`  in  `addrN`  request address
- `c0_we`, `c1_we`  in  1  1 = write, 0 = read
- `c0_di`, `c1_di`  in  `intN`  write data
- `c0_do`, `c1_do`  out  `intN`  read data
- `c0_do_valid`, `c1_do_valid`  out  1  one-cycle read-response strobe
- `arr_valid`  out  1  request to array
- `arr_ready`  in  1  array accepts request
- `arr_addr`  out  `addrN`, `arr_we` out 1, `arr_di` out `intN`  request fields
- `arr_do`  in  `intN`  array read data, valid the cycle after a read is accepted

## Operation
- Slot FSM: EMPTY (`arr_valid`=0) / FULL (`arr_valid`=1, fields held stable).
- Slot can load when EMPTY, or FULL and `arr_ready`=1 (drain+load same cycle, full throughput).
- Winner: if only one client valid, it wins; if both, the client not equal to `last` wins. `last` updates to the winner on each load.
- `cX_ready` = slot can load and X is the winner; the loser sees ready=0 and must hold valid and fields stable (no combinational path from `cX_ready` to `cX_valid` required).
- On load: slot := {winner addr, we, di}, `slot_owner` := winner.
- FULL→EMPTY: `arr_ready`=1 and no client valid.
- Response: on acceptance of a slot with `we`=0, set `rd_pend`=1, `rd_owner`=`slot_owner`. Next cycle: `c<rd_owner>_do_valid`=1, both `cX_do` = `arr_do` (combinational pass-through), `rd_pend` clears unless another read is accepted that cycle.
- Writes produce no response strobe.
- Never more than one read outstanding.

## Timing
- Reset (async, `nrst`=0): slot EMPTY, `arr_valid`=0, `arr_addr`/`arr_di`/`arr_we`=0, `last`=1 (c0 wins first tie), `rd_pend`=0, both `do_valid`=0, both `ready`=0 while in reset.
- Request latency: client handshake at cycle t → `arr_valid` at t+1.
- Read latency: client handshake t → array accept ≥ t+1 → `do_valid` at accept+1; minimum 2 cycles.
- Sustained both-valid with `arr_ready`=1: grants alternate c0,c1,c0,… one per cycle.
- `arr_ready`=0 while FULL: both `cX_ready`=0, slot unchanged, `last` unchanged.
- Reset mid-operation: in-flight slot and pending response are dropped; no `do_valid` after reset release until a new read is accepted.

## Structure
- Shared package/`primitives.v` additions: slot-state encodings `EMPTY`/`FULL`, client index width constant.
- Optional sub-module `rr_pick2`: combinational 2-way round-robin selector (valids, last → winner, any). Remainder is a single module.

## Test plan
- Single client c0 writes 0x05→addr 3, then reads addr 3 → one `arr_valid` cycle per request, `c0_do_valid` at read-accept+1 with `c0_do`=5; `c1_do_valid` stays 0.
- Both clients continuously valid, `arr_ready`=1 → c0 at t+1, then c1,c0,c1 at consecutive cycles; no gaps.
- Both valid, `arr_ready` held 0 for 5 cycles → slot fields constant, both `ready`=0, `last` unchanged; on release, the alternation resumes at the correct client.
- Interleaved reads: c0 reads addr 1 (=0x11), c1 reads addr 2 (=0x22) back-to-back → `c0_do_valid` with 0x11 then `c1_do_valid` with 0x22 on consecutive cycles.
- Assert `nrst`=0 while FULL with a read outstanding → `arr_valid`, `do_valid` drop immediately; after release, first tie goes to c0.
- Mixed write/read stream from c1 only (W,R,W,R) → exactly two `c1_do_valid` strobes with data reflecting preceding writes.
